// File: rtl/qoa_pkg.sv
// Shared constants and types for the QOA decoder and its SPI front end.
package qoa_pkg;

    localparam int unsigned QOA_SAMPLE_W = 16;
    localparam int unsigned QOA_BYTE_W   = 8;

    // Command-byte field positions
    localparam int unsigned CMD_SAMPLE_BIT = 0;
    localparam int unsigned HW_SEL_BIT     = 1;
    localparam int unsigned HW_IDX_LSB     = 2;
    localparam int unsigned HW_IDX_MSB     = 3;
    localparam int unsigned R_IDX_LSB      = 1;
    localparam int unsigned R_IDX_MSB      = 3;
    localparam int unsigned SF_IDX_LSB     = 4;
    localparam int unsigned SF_IDX_MSB     = 7;

    // Front-end transaction state, mirrors the synchronised chip select
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } fe_state_e;

endpackage

// File: rtl/qoa_spi_frontend_if.sv
// SPI pins plus decoder-facing byte/sample signals of the front end.
interface qoa_spi_frontend_if
    import qoa_pkg::*;
#(
    parameter int unsigned SAMPLE_W = QOA_SAMPLE_W
);
    logic                  spi_sck;
    logic                  spi_cs_n;
    logic                  spi_mosi;
    logic                  spi_miso;
    logic [SAMPLE_W-1:0]   sample;
    logic [QOA_BYTE_W-1:0] spi_in;
    logic                  data_rdy;

    modport slave (
        input  spi_sck, spi_cs_n, spi_mosi, sample,
        output spi_miso, spi_in, data_rdy
    );

    modport master (
        output spi_sck, spi_cs_n, spi_mosi, sample,
        input  spi_miso, spi_in, data_rdy
    );
endinterface

// File: rtl/qoa_sync.sv
// Multi-flop single-bit synchroniser with a configurable reset value.
module qoa_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] sync_d;
    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the raw pin into the chain
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    // Synchroniser flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= {SYNC_STAGES{RST_VAL}};
        else        sync_q <= sync_d;
    end

    assign q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/qoa_spi_frontend.sv
// SPI mode-0 slave front end: assembles MOSI bytes for the decoder and
// returns the decoder's current sample on MISO each transaction.
module qoa_spi_frontend
    import qoa_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SAMPLE_W    = QOA_SAMPLE_W
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    qoa_spi_frontend_if.slave  bus
);
    localparam int unsigned BIT_CNT_W = $clog2(QOA_BYTE_W);
    localparam int unsigned TX_CNT_W  = $clog2(SAMPLE_W + 1);

    logic sck_s, cs_s, mosi_s;
    logic sck_p_q, cs_p_q;
    logic sck_rise, sck_fall, cs_start, cs_end, cs_end_v;

    fe_state_e              state_d,    state_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_d,  bit_cnt_q;
    logic [QOA_BYTE_W-1:0]  rx_shift_d, rx_shift_q;
    logic [QOA_BYTE_W-1:0]  spi_in_d,   spi_in_q;
    logic                   data_rdy_d, data_rdy_q;
    logic [SAMPLE_W-1:0]    tx_shift_d, tx_shift_q;
    logic [TX_CNT_W-1:0]    tx_cnt_d,   tx_cnt_q;
    logic                   miso_d,     miso_q;

    qoa_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(sys_clk), .rst_n(sys_rst_n), .d(bus.spi_sck), .q(sck_s)
    );
    qoa_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(sys_clk), .rst_n(sys_rst_n), .d(bus.spi_cs_n), .q(cs_s)
    );
    qoa_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(sys_clk), .rst_n(sys_rst_n), .d(bus.spi_mosi), .q(mosi_s)
    );

    // Edge history for sck and cs_n
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sck_p_q <= 1'b0;
            cs_p_q  <= 1'b1;
        end else begin
            sck_p_q <= sck_s;
            cs_p_q  <= cs_s;
        end
    end

    // SCK edges only count inside a selected frame; a rise on the cs_end cycle is dropped
    assign sck_rise = sck_s & ~sck_p_q & ~cs_s;
    assign sck_fall = ~sck_s & sck_p_q & ~cs_s;
    assign cs_start = ~cs_s & cs_p_q;
    assign cs_end   = cs_s & ~cs_p_q;
    assign cs_end_v = cs_end & (state_q == ST_ACTIVE);

    // Next-state: frame tracking, receive shifter, transmit shifter
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        spi_in_d   = spi_in_q;
        data_rdy_d = 1'b0;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        miso_d     = 1'b0;

        if (cs_start) begin
            state_d    = ST_ACTIVE;
            bit_cnt_d  = '0;
            tx_shift_d = bus.sample;
            tx_cnt_d   = '0;
        end else if (cs_end_v) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
        end

        // bit_cnt_d already reflects a same-cycle cs_start clear
        if (sck_rise) begin
            rx_shift_d = {rx_shift_q[QOA_BYTE_W-2:0], mosi_s};
            if (bit_cnt_d == BIT_CNT_W'(QOA_BYTE_W - 1)) begin
                spi_in_d   = rx_shift_d;
                data_rdy_d = 1'b1;
            end
            bit_cnt_d = bit_cnt_d + BIT_CNT_W'(1);
        end

        // A freshly captured sample is never shifted in its capture cycle
        if (sck_fall && !cs_start) begin
            tx_shift_d = {tx_shift_q[SAMPLE_W-2:0], 1'b0};
            if (tx_cnt_q != TX_CNT_W'(SAMPLE_W)) begin
                tx_cnt_d = tx_cnt_q + TX_CNT_W'(1);
            end
        end

        if (!cs_s) begin
            miso_d = tx_shift_d[SAMPLE_W-1];
        end
    end

    // State and output registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            spi_in_q   <= '0;
            data_rdy_q <= 1'b0;
            tx_shift_q <= '0;
            tx_cnt_q   <= '0;
            miso_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            spi_in_q   <= spi_in_d;
            data_rdy_q <= data_rdy_d;
            tx_shift_q <= tx_shift_d;
            tx_cnt_q   <= tx_cnt_d;
            miso_q     <= miso_d;
        end
    end

    assign bus.spi_in   = spi_in_q;
    assign bus.data_rdy = data_rdy_q;
    assign bus.spi_miso = miso_q;
endmodule

// File: doc/qoa_spi_frontend.md
Name: qoa_spi_frontend

Overview:
SPI-slave front end that sits directly upstream of the QOA decoder core.
- Samples asynchronous SPI pins in the sys_clk domain and assembles MOSI bytes.
- Presents each completed byte to the decoder as spi_in with a one-cycle data_rdy pulse.
- At the start of each transaction, captures the decoder's current 16-bit sample and shifts it back out on MISO.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on spi_sck, spi_cs_n and spi_mosi (legal 2..3).
SAMPLE_W, 16, width of the sample word returned on MISO.

Ports:
sys_clk  input  1  system clock; all logic on its rising edge.
sys_rst_n  input  1  asynchronous, active-low reset.
spi_sck  input  1  SPI clock, asynchronous to sys_clk; mode 0 (CPOL=0, CPHA=0).
spi_cs_n  input  1  SPI chip select, active low, asynchronous.
spi_mosi  input  1  SPI data in, MSB first.
spi_miso  output  1  SPI data out, MSB first.
sample  input  SAMPLE_W  decoded sample from the decoder core.
spi_in  output  8  last completed received byte; held until the next byte completes.
data_rdy  output  1  one-cycle pulse; spi_in is valid in that same cycle.

Behaviour:
Reset values (applied asynchronously while sys_rst_n=0):
- spi_in=0, data_rdy=0, spi_miso=0.
- Bit counter=0, rx/tx shift registers=0, sync chains=0 (sck and mosi), 1 (cs_n).
- Edge-detect history registers match their sync-chain reset values.

Synchronisation and edge detection:
- Each pin passes through SYNC_STAGES flops. sck_s, cs_s and mosi_s denote the sync outputs.
- One extra register per signal holds the previous value (sck_p, cs_p).
- sck_rise = sck_s & ~sck_p; sck_fall = ~sck_s & sck_p.
- cs_start = ~cs_s & cs_p; cs_end = cs_s & ~cs_p.
- sck_rise and sck_fall are ignored while cs_s=1.

Receive path:
- On sck_rise: rx_shift <= {rx_shift[6:0], mosi_s}; bit_cnt <= bit_cnt+1 (3-bit, wraps 7->0).
- On an sck_rise with bit_cnt==7: spi_in <= {rx_shift[6:0], mosi_s} and data_rdy <= 1, both registered.
- Latency: data_rdy is high in the cycle after the sys_clk cycle in which the 8th sck_rise is detected.
- data_rdy is high for exactly one cycle per byte. Consecutive bytes in one transaction each produce their own pulse.
- cs_end with bit_cnt!=0: the partial byte is discarded, bit_cnt <= 0, no data_rdy, spi_in unchanged.
- cs_start: bit_cnt <= 0.

Transmit path:
- On cs_start: tx_shift <= sample (captured in that cycle); tx_cnt <= 0.
- spi_miso = tx_shift[SAMPLE_W-1] whenever cs_s=0; spi_miso=0 whenever cs_s=1. The output is registered.
- On sck_fall while cs_s=0: tx_shift <= {tx_shift[SAMPLE_W-2:0], 1'b0}. tx_cnt saturates at SAMPLE_W.
- After SAMPLE_W bits, MISO shifts out 0s until cs_end.
- sample changing mid-transaction has no effect on MISO.

State (implicit in cs_s): IDLE (cs_s=1) and ACTIVE (cs_s=0).
- IDLE -> ACTIVE on cs_start.
- ACTIVE -> IDLE on cs_end.

Simultaneous events:
- cs_start and sck_rise in the same cycle: cs_start clears bit_cnt first, then the rise counts as bit 0.
- cs_end and sck_rise in the same cycle: cs_end wins and the bit is dropped.

Timing constraint on the host:
- SCK high and low times are each >= (SYNC_STAGES+2) sys_clk periods.
- CS setup before the first SCK rise is >= (SYNC_STAGES+2) periods.
- Because SCK is at most sys_clk/8, the decoder (at most 6 cycles per byte) always finishes before the next data_rdy. No overrun handling is required.
- Reset mid-transaction aborts everything. After release, the block waits for a fresh cs_start; any SCK edges seen before cs_start are ignored.

Decomposition:
- Shared package qoa_pkg holds:
  - QOA_SAMPLE_W = 16 and QOA_BYTE_W = 8.
  - Command-byte field constants: CMD_SAMPLE bit 0; HW_SEL bit 1; HW_IDX [3:2]; R_IDX [3:1]; SF_IDX [7:4].
- One sub-module: qoa_sync (parameterised SYNC_STAGES single-bit synchroniser with async reset and a reset-value parameter), instantiated three times.

Test Plan:
1. Reset, CS low, clock in 0xA5 at sys_clk/8 SCK -> a single data_rdy pulse with spi_in=0xA5, exactly 1 cycle after the 8th detected rise.
2. Three bytes 0x01, 0x7F, 0x80 in one CS frame -> three data_rdy pulses with spi_in matching in order; spi_in holds 0x80 after CS rises.
3. sample=0xBEEF held before CS falls, 24 SCK cycles -> MISO reads 0xBEEF MSB-first, then 8 zeros; changing sample to 0x1234 mid-frame does not alter MISO.
4. Send 5 bits, raise CS, then a new frame with byte 0x3C -> no pulse for the partial byte; one pulse with spi_in=0x3C.
5. Assert sys_rst_n=0 after 4 bits of a byte, release, new frame sending 0xC3 -> outputs at reset values during reset; one pulse with spi_in=0xC3; MISO=0 while CS is high.
6. Command stream 0x02, 0x12, 0x34 (weight write), then 0x11, driven into the decoder core -> four data_rdy pulses spaced ≥64 sys_clk apart; no byte is lost.
